// File: rtl/pr_freeze_seq_pkg.sv
// Shared types for the PR freeze sequencer: state encoding visible through CSR readback.
package pr_freeze_seq_pkg;

   localparam int unsigned SEQ_STATE_W = 3;

   typedef enum logic [SEQ_STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_FREEZE   = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_RESET    = 3'd3,
      ST_PR_WAIT  = 3'd4,
      ST_RELEASE  = 3'd5,
      ST_UNFREEZE = 3'd6
   } pr_seq_state_e;

endpackage

// File: rtl/pr_freeze_sequencer.sv
// PR freeze sequencer: freeze bridges, drain, hold AFU in soft reset during load,
// then release reset and freeze in order.
// Optional feature macro: PR_DRAIN_TIMEOUT_EN (bounded DRAIN with sticky timeout flag).
module pr_freeze_sequencer
   import pr_freeze_seq_pkg::*;
#(
   parameter int unsigned NUM_IFC            = 3,
   parameter int unsigned FREEZE_SYNC_CYCLES = 8,
   parameter int unsigned DRAIN_TIMEOUT      = 65535,
   parameter int unsigned RST_HOLD_CYCLES    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pr_start_req,
   output logic                   pr_start_ack,
   input  logic                   pr_done,
   input  logic                   pr_error,
   input  logic [NUM_IFC-1:0]     ifc_idle,
   output logic                   pr_freeze,
   output logic                   softreset,
   input  logic                   err_clr,
   output logic                   pr_err,
   output logic                   drain_timeout_err,
   output logic [SEQ_STATE_W-1:0] seq_state
);

   localparam int unsigned MAX_FD  = (FREEZE_SYNC_CYCLES > DRAIN_TIMEOUT) ? FREEZE_SYNC_CYCLES : DRAIN_TIMEOUT;
   localparam int unsigned MAX_CNT = (MAX_FD > RST_HOLD_CYCLES) ? MAX_FD : RST_HOLD_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

   // A state loaded with N-1 occupies exactly N cycles before its counter hits 0.
   localparam logic [CNT_W-1:0] FREEZE_LD = CNT_W'((FREEZE_SYNC_CYCLES == 0) ? 0 : FREEZE_SYNC_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LD    = CNT_W'((RST_HOLD_CYCLES == 0) ? 0 : RST_HOLD_CYCLES - 1);
   // Release hold includes the cycle softreset drops, so freeze stays up a full
   // RST_HOLD_CYCLES after the AFU has left reset.
   localparam logic [CNT_W-1:0] REL_LD    = CNT_W'(RST_HOLD_CYCLES);
`ifdef PR_DRAIN_TIMEOUT_EN
   localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);
`endif

   pr_seq_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q;
   logic             req_edge;
   logic             freeze_d, softreset_d, ack_d;
   logic             pr_err_set;
`ifdef PR_DRAIN_TIMEOUT_EN
   logic             dto_set;
`endif

   assign req_edge  = pr_start_req & ~req_q;
   assign seq_state = state_q;

   // Next-state, shared counter and next output values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      pr_err_set  = 1'b0;
`ifdef PR_DRAIN_TIMEOUT_EN
      dto_set     = 1'b0;
`endif
      freeze_d    = 1'b0;
      softreset_d = 1'b0;
      ack_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_edge) begin
               state_d = ST_FREEZE;
               cnt_d   = FREEZE_LD;
            end
         end
         ST_FREEZE: begin
            if (cnt_q == '0) begin
               state_d = ST_DRAIN;
`ifdef PR_DRAIN_TIMEOUT_EN
               cnt_d   = DRAIN_LD;
`else
               cnt_d   = '0;
`endif
            end
         end
         ST_DRAIN: begin
            if (&ifc_idle) begin
               state_d = ST_RESET;
               cnt_d   = RST_LD;
            end
`ifdef PR_DRAIN_TIMEOUT_EN
            else if (cnt_q == '0) begin
               state_d = ST_RESET;
               cnt_d   = RST_LD;
               dto_set = 1'b1;
            end
`endif
         end
         ST_RESET: begin
            if (cnt_q == '0) begin
               state_d = ST_PR_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PR_WAIT: begin
            pr_err_set = pr_error;
            if (pr_done || pr_error) begin
               state_d = ST_RELEASE;
               cnt_d   = REL_LD;
            end
         end
         ST_RELEASE: begin
            if (cnt_q == '0) begin
               state_d = ST_UNFREEZE;
               cnt_d   = '0;
            end
         end
         ST_UNFREEZE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      unique case (state_d)
         ST_FREEZE, ST_DRAIN, ST_RELEASE: freeze_d = 1'b1;
         ST_RESET: begin
            freeze_d    = 1'b1;
            softreset_d = 1'b1;
         end
         ST_PR_WAIT: begin
            freeze_d    = 1'b1;
            softreset_d = 1'b1;
            ack_d       = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counter, request edge history and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         req_q        <= pr_start_req;
         pr_freeze    <= 1'b0;
         softreset    <= 1'b0;
         pr_start_ack <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= pr_start_req;
         pr_freeze    <= freeze_d;
         softreset    <= softreset_d;
         pr_start_ack <= ack_d;
      end
   end

   // Sticky error flags; a set wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         pr_err            <= 1'b0;
         drain_timeout_err <= 1'b0;
      end else begin
         pr_err            <= pr_err_set | (pr_err & ~err_clr);
`ifdef PR_DRAIN_TIMEOUT_EN
         drain_timeout_err <= dto_set | (drain_timeout_err & ~err_clr);
`else
         drain_timeout_err <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_pr_freeze_sequencer.sv
// Directed bench for pr_freeze_sequencer with default timing parameters.
module tb_pr_freeze_sequencer;

   localparam int unsigned NUM_IFC = 3;
`ifdef PR_DRAIN_TIMEOUT_EN
   localparam int unsigned DTO        = 50;
   localparam int          DRAIN_WAIT = 40;
`else
   localparam int unsigned DTO        = 65535;
   localparam int          DRAIN_WAIT = 100;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic               pr_start_req;
   logic               pr_start_ack;
   logic               pr_done;
   logic               pr_error;
   logic [NUM_IFC-1:0] ifc_idle;
   logic               pr_freeze;
   logic               softreset;
   logic               err_clr;
   logic               pr_err;
   logic               drain_timeout_err;
   logic [2:0]         seq_state;

   int checks   = 0;
   int failures = 0;

   pr_freeze_sequencer #(
      .NUM_IFC            (NUM_IFC),
      .FREEZE_SYNC_CYCLES (8),
      .DRAIN_TIMEOUT      (DTO),
      .RST_HOLD_CYCLES    (16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pr_start_req      (pr_start_req),
      .pr_start_ack      (pr_start_ack),
      .pr_done           (pr_done),
      .pr_error          (pr_error),
      .ifc_idle          (ifc_idle),
      .pr_freeze         (pr_freeze),
      .softreset         (softreset),
      .err_clr           (err_clr),
      .pr_err            (pr_err),
      .drain_timeout_err (drain_timeout_err),
      .seq_state         (seq_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, output int n);
      n = 0;
      while (seq_state !== target && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; pr_start_req = 1'b1; pr_done = 1'b0; pr_error = 1'b0;
      ifc_idle = 3'b111; err_clr = 1'b0;
      tick(); tick();
      checks++;
      if ({pr_freeze, softreset, pr_start_ack, pr_err, drain_timeout_err, seq_state} !== 8'b0) begin
         failures++;
         $display("FAIL reset_values got=%b want=00000000",
                  {pr_freeze, softreset, pr_start_ack, pr_err, drain_timeout_err, seq_state});
      end
      reset = 1'b0;
      repeat (5) tick();
      checks++;
      if (seq_state !== 3'd0 || pr_freeze !== 1'b0) begin
         failures++;
         $display("FAIL held_req_after_reset state=%0d freeze=%b want state=0 freeze=0", seq_state, pr_freeze);
      end
      pr_start_req = 1'b0;
      tick();
   endtask

   task automatic test_normal_entry();
      int n;
      logic [15:0] vis;
      logic [2:0]  last;
      ifc_idle = 3'b111;
      pr_start_req = 1'b1;
      tick();
      checks++;
      if (pr_freeze !== 1'b1 || seq_state !== 3'd1) begin
         failures++;
         $display("FAIL freeze_after_edge freeze=%b state=%0d want freeze=1 state=1", pr_freeze, seq_state);
      end
      n = 0; vis = 16'h0001; last = 3'd1;
      while (pr_start_ack !== 1'b1 && n < 200) begin
         tick();
         n++;
         if (seq_state !== last) begin
            vis  = {vis[11:0], 1'b0, seq_state};
            last = seq_state;
         end
      end
      checks++;
      if (n != 25) begin
         failures++;
         $display("FAIL freeze_to_ack_latency got=%0d want=25", n);
      end
      checks++;
      if (vis !== 16'h1234) begin
         failures++;
         $display("FAIL state_visit_order got=%h want=1234", vis);
      end
      checks++;
      if (softreset !== 1'b1 || pr_freeze !== 1'b1) begin
         failures++;
         $display("FAIL pr_wait_outputs softreset=%b freeze=%b want 1 1", softreset, pr_freeze);
      end
   endtask

   task automatic test_done_release();
      int n;
      pr_done = 1'b1;
      tick();
      pr_done = 1'b0;
      checks++;
      if (softreset !== 1'b0 || pr_start_ack !== 1'b0 || pr_freeze !== 1'b1 || seq_state !== 3'd5) begin
         failures++;
         $display("FAIL release_entry sr=%b ack=%b fr=%b st=%0d want 0 0 1 5",
                  softreset, pr_start_ack, pr_freeze, seq_state);
      end
      n = 0;
      while (pr_freeze === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 17 || seq_state !== 3'd6) begin
         failures++;
         $display("FAIL unfreeze_delay got=%0d state=%0d want=17 state=6", n, seq_state);
      end
      tick();
      checks++;
      if (seq_state !== 3'd0 || pr_err !== 1'b0) begin
         failures++;
         $display("FAIL back_to_idle state=%0d pr_err=%b want 0 0", seq_state, pr_err);
      end
      repeat (5) tick();
      checks++;
      if (seq_state !== 3'd0 || pr_freeze !== 1'b0) begin
         failures++;
         $display("FAIL held_req_no_restart state=%0d freeze=%b want 0 0", seq_state, pr_freeze);
      end
      pr_start_req = 1'b0;
      tick();
   endtask

   task automatic test_drain_wait_and_error();
      int n;
      int bad;
      ifc_idle = 3'b101;
      pr_start_req = 1'b1;
      tick();
      pr_start_req = 1'b0;
      wait_state(3'd2, 50, n);
      checks++;
      if (n != 8) begin
         failures++;
         $display("FAIL freeze_sync_len got=%0d want=8", n);
      end
      bad = 0;
      repeat (DRAIN_WAIT) begin
         tick();
         if (seq_state !== 3'd2 || softreset !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL drain_holds_not_idle bad_cycles=%0d want=0", bad);
      end
      ifc_idle = 3'b111;
      tick();
      checks++;
      if (softreset !== 1'b1 || seq_state !== 3'd3 || drain_timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL drain_exit sr=%b st=%0d dto=%b want 1 3 0", softreset, seq_state, drain_timeout_err);
      end
      wait_state(3'd4, 100, n);
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL reset_hold got=%0d want=16", n);
      end
      pr_error = 1'b1;
      tick();
      pr_error = 1'b0;
      checks++;
      if (pr_err !== 1'b1 || softreset !== 1'b0 || seq_state !== 3'd5) begin
         failures++;
         $display("FAIL error_release pr_err=%b sr=%b st=%0d want 1 0 5", pr_err, softreset, seq_state);
      end
      wait_state(3'd0, 100, n);
      checks++;
      if (n != 18 || pr_freeze !== 1'b0) begin
         failures++;
         $display("FAIL error_to_idle got=%0d freeze=%b want=18 0", n, pr_freeze);
      end
      pr_done = 1'b1;
      tick();
      pr_done = 1'b0;
      tick();
      checks++;
      if (seq_state !== 3'd0 || pr_freeze !== 1'b0 || softreset !== 1'b0 || pr_err !== 1'b1) begin
         failures++;
         $display("FAIL done_in_idle st=%0d fr=%b sr=%b pr_err=%b want 0 0 0 1",
                  seq_state, pr_freeze, softreset, pr_err);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (pr_err !== 1'b0) begin
         failures++;
         $display("FAIL err_clr pr_err=%b want 0", pr_err);
      end
   endtask

   task automatic test_set_beats_clear();
      int n;
      pr_start_req = 1'b1;
      tick();
      pr_start_req = 1'b0;
      wait_state(3'd4, 100, n);
      checks++;
      if (n != 25) begin
         failures++;
         $display("FAIL second_seq_latency got=%0d want=25", n);
      end
      pr_done = 1'b1; pr_error = 1'b1; err_clr = 1'b1;
      tick();
      pr_done = 1'b0; pr_error = 1'b0; err_clr = 1'b0;
      checks++;
      if (pr_err !== 1'b1 || seq_state !== 3'd5) begin
         failures++;
         $display("FAIL set_beats_clear pr_err=%b st=%0d want 1 5", pr_err, seq_state);
      end
      wait_state(3'd0, 100, n);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      pr_start_req = 1'b1;
      tick();
      pr_start_req = 1'b0;
      wait_state(3'd4, 100, n);
      pr_done = 1'b1;
      tick();
      pr_done = 1'b0;
      wait_state(3'd0, 100, n);
      pr_start_req = 1'b1;
      tick();
      checks++;
      if (seq_state !== 3'd1 || pr_freeze !== 1'b1) begin
         failures++;
         $display("FAIL restart_from_idle st=%0d fr=%b want 1 1", seq_state, pr_freeze);
      end
      pr_start_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      wait_state(3'd4, 100, n);
      checks++;
      if (seq_state !== 3'd4) begin
         failures++;
         $display("FAIL reach_pr_wait st=%0d want 4", seq_state);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({pr_freeze, softreset, pr_start_ack, seq_state} !== 6'b0) begin
         failures++;
         $display("FAIL reset_in_pr_wait got=%b want=000000", {pr_freeze, softreset, pr_start_ack, seq_state});
      end
      tick();
   endtask

`ifdef PR_DRAIN_TIMEOUT_EN
   task automatic test_drain_timeout();
      int n;
      ifc_idle = 3'b000;
      pr_start_req = 1'b1;
      tick();
      pr_start_req = 1'b0;
      wait_state(3'd2, 50, n);
      wait_state(3'd3, 200, n);
      checks++;
      if (n != 50 || drain_timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL drain_timeout cycles=%0d dto=%b want=50 1", n, drain_timeout_err);
      end
      ifc_idle = 3'b111;
      wait_state(3'd4, 100, n);
      pr_done = 1'b1;
      tick();
      pr_done = 1'b0;
      wait_state(3'd0, 100, n);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (drain_timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL dto_clear dto=%b want 0", drain_timeout_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_normal_entry();
      test_done_release();
      test_drain_wait_and_error();
      test_set_beats_clear();
      test_back_to_back();
      test_reset_mid();
`ifdef PR_DRAIN_TIMEOUT_EN
      test_drain_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pr_freeze_sequencer.md
# pr_freeze_sequencer

Sequences one partial-reconfiguration event for the PR slot. It freezes the PR-boundary bridges and waits for the PCIe, EMIF and HSSI bridge groups to drain. It then holds the AFU in soft reset while the bitstream loads, and releases reset and freeze in a fixed order. It sits in the port gasket between the PR controller/CSR interface and the `pr_freeze` and `softreset` inputs of the PR slot.

## Interface
Parameters:
- `NUM_IFC`, 3 — number of bridge groups reporting idle (PCIe, EMIF, HSSI).
- `FREEZE_SYNC_CYCLES`, 8 — cycles from freeze assertion until idle is trusted. Covers the bridge-side resync chains.
- `DRAIN_TIMEOUT`, 65535 — maximum cycles spent in DRAIN when the timeout feature is compiled in.
- `RST_HOLD_CYCLES`, 16 — minimum softreset hold before ack, and freeze hold after reset release.

Ports:
- `clk`  in  1  — FIM clock; all logic on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `pr_start_req`  in  1  — PR request from the PR controller; a rising edge starts a sequence.
- `pr_start_ack`  out  1  — region frozen and reset, safe to reconfigure.
- `pr_done`  in  1  — single-cycle pulse: bitstream load complete.
- `pr_error`  in  1  — single-cycle pulse: bitstream load failed.
- `ifc_idle`  in  NUM_IFC  — per-group "no outstanding transactions", already synchronized to `clk`.
- `pr_freeze`  out  1  — freeze to PR-boundary bridges.
- `softreset`  out  1  — AFU soft reset, active-high.
- `err_clr`  in  1  — clears the sticky error flags.
- `pr_err`  out  1  — sticky: `pr_error` was seen.
- `drain_timeout_err`  out  1  — sticky: drain timed out.
- `seq_state`  out  3  — current state encoding, for CSR readback.

## Operation
- The FSM has seven states: IDLE=0, FREEZE=1, DRAIN=2, RESET=3, PR_WAIT=4, RELEASE=5, UNFREEZE=6.
- IDLE:
  - Outputs: freeze=0, softreset=0, ack=0.
  - A rising edge of `pr_start_req` (req=1 and the previous-cycle req=0) moves to FREEZE.
  - A req held high across reset or across the return to IDLE does not start a new sequence.
- FREEZE:
  - Outputs: freeze=1.
  - A counter runs for FREEZE_SYNC_CYCLES, then the FSM moves to DRAIN.
- DRAIN:
  - Outputs: freeze=1.
  - Moves to RESET when `&ifc_idle` is 1.
- RESET:
  - Outputs: freeze=1, softreset=1.
  - Held for RST_HOLD_CYCLES, then moves to PR_WAIT.
- PR_WAIT:
  - Outputs: freeze=1, softreset=1, ack=1.
  - `pr_done` or `pr_error` moves to RELEASE. `pr_error` also sets `pr_err`; if both pulse in the same cycle, `pr_err` is still set.
- RELEASE:
  - Outputs: freeze=1, softreset=0, ack=0.
  - Held for RST_HOLD_CYCLES, then moves to UNFREEZE.
- UNFREEZE:
  - Outputs: freeze=0.
  - Moves to IDLE on the next cycle.
- Inputs ignored outside their states:
  - `pr_start_req` edges outside IDLE.
  - `pr_done` and `pr_error` outside PR_WAIT.
  - `ifc_idle` outside DRAIN.
- Counters:
  - One shared down-counter, width `$clog2(max(FREEZE_SYNC_CYCLES, DRAIN_TIMEOUT, RST_HOLD_CYCLES)+1)`.
  - Loaded on every state entry; no wrap.
  - Reaching 0 is the exit condition.
- Sticky errors:
  - Set dominates `err_clr` in the same cycle.
  - Both flags are cleared only by `err_clr` or `reset`.
- `reset` mid-sequence:
  - All outputs go to their reset values on the next edge and the FSM returns to IDLE.
  - This drops freeze immediately. The system must not assert `reset` during PR.

## Timing
- All outputs are registered.
- Reset values: freeze=0, softreset=0, ack=0, pr_err=0, drain_timeout_err=0, seq_state=0.
- `pr_freeze` goes high 1 cycle after the req edge is sampled.
- Minimum latency from freeze to `pr_start_ack`, with all groups idle: FREEZE_SYNC_CYCLES + 1 + RST_HOLD_CYCLES cycles.
- `softreset` goes low 1 cycle after `pr_done`.
- `pr_freeze` goes low RST_HOLD_CYCLES+1 cycles after `softreset` goes low.
- A new sequence can start 1 cycle after entering IDLE.

## Configuration
- `PR_DRAIN_TIMEOUT_EN` defined:
  - DRAIN also exits to RESET when the counter (loaded with DRAIN_TIMEOUT) reaches 0 while not all groups are idle.
  - `drain_timeout_err` is set on that exit.
- `PR_DRAIN_TIMEOUT_EN` not defined:
  - DRAIN waits indefinitely for idle.
  - `drain_timeout_err` is tied to 0.

## Structure
- `pr_freeze_seq_pkg` contains:
  - the `pr_seq_state_e` enum, 3 bits, with the encodings above;
  - the `SEQ_STATE_W` constant.
- No sub-module is needed; the FSM, counter, edge detect and sticky flags live in one module.

## Test plan
- Req edge with `ifc_idle`=3'b111 and default parameters -> freeze high 1 cycle after the sampled edge; ack high 25 cycles later; states visit 1,2,3,4 in order.
- `ifc_idle`=3'b101 for 100 cycles in DRAIN, then 3'b111 -> softreset rises 1 cycle after idle; `drain_timeout_err`=0.
- `PR_DRAIN_TIMEOUT_EN` with DRAIN_TIMEOUT=50 and `ifc_idle`=0 -> RESET entered after 50 DRAIN cycles; `drain_timeout_err`=1; `err_clr` pulse -> flag returns to 0.
- `pr_done` pulse in PR_WAIT -> softreset low next cycle; freeze low 17 cycles later; IDLE reached; req still high does not restart the sequence.
- `pr_error` pulse in PR_WAIT -> `pr_err`=1 with the same release sequence; `pr_done` pulsed in IDLE -> no effect.
- `reset` asserted in PR_WAIT -> next cycle freeze=0, softreset=0, ack=0, seq_state=0.
